// File: rtl/io_fabric_pkg.sv
// Shared types and constants for the io_fabric CPU-to-peripheral bus fabric.
package io_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] OFS_PENDING  = 4'h0;
   localparam logic [3:0] OFS_MASK     = 4'h4;
   localparam logic [3:0] OFS_ERR_ADDR = 4'h8;

   localparam int   ERR_FLAG_BIT = 31;
   localparam logic ERR_RDATA    = 1'b1;
   localparam int   TCNT_W       = 8;

endpackage

// File: rtl/io_fabric_if.sv
// CPU-side request/response bus plus peripheral channel bus of io_fabric.
interface io_fabric_if #(
   parameter int NSLAVE = 4,
   parameter int AW     = 11,
   parameter int DW     = 32
);
   logic                 read;
   logic                 write;
   logic [AW-1:0]        address;
   logic [DW-1:0]        data_in;
   logic [DW/8-1:0]      be;
   logic [DW-1:0]        data_out;
   logic                 wait_out;
   logic                 bus_err;
   logic [NSLAVE-1:0]    slv_sel;
   logic                 slv_read;
   logic                 slv_write;
   logic [AW-1:0]        slv_addr;
   logic [DW-1:0]        slv_wdata;
   logic [DW/8-1:0]      slv_be;
   logic [NSLAVE*DW-1:0] slv_rdata;
   logic [NSLAVE-1:0]    slv_ack;
   logic [NSLAVE-1:0]    irq_in;
   logic                 interrupt;

   // master: CPU and peripherals around the fabric
   modport master (
      output read, write, address, data_in, be, slv_rdata, slv_ack, irq_in,
      input  data_out, wait_out, bus_err, slv_sel, slv_read, slv_write,
             slv_addr, slv_wdata, slv_be, interrupt
   );

   // slave: the fabric itself
   modport slave (
      input  read, write, address, data_in, be, slv_rdata, slv_ack, irq_in,
      output data_out, wait_out, bus_err, slv_sel, slv_read, slv_write,
             slv_addr, slv_wdata, slv_be, interrupt
   );
endinterface

// File: rtl/io_fabric_irq_ctrl.sv
// Per-channel interrupt capture: input register, rising-edge detect,
// write-1-clear pending bits, byte-enabled mask and registered interrupt.
module io_irq_ctrl #(
   parameter int NSLAVE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSLAVE-1:0] i_irq,
   input  logic              i_clr_en,
   input  logic              i_mask_we,
   input  logic [NSLAVE-1:0] i_wdata,
   input  logic [NSLAVE-1:0] i_bit_en,
   output logic [NSLAVE-1:0] o_pending,
   output logic [NSLAVE-1:0] o_mask,
   output logic              o_interrupt
);

   logic [NSLAVE-1:0] r_sync;
   logic [NSLAVE-1:0] r_prev;
   logic [NSLAVE-1:0] r_pending;
   logic [NSLAVE-1:0] r_mask;
   logic              r_irq;
   logic [NSLAVE-1:0] w_rise;
   logic [NSLAVE-1:0] w_clr;

   assign w_rise = r_sync & ~r_prev;
   assign w_clr  = i_clr_en ? (i_wdata & i_bit_en) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync    <= '0;
         r_prev    <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_sync    <= i_irq;
         r_prev    <= r_sync;
         // a new edge beats a simultaneous clear of the same bit
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (i_mask_we) begin
            r_mask <= (r_mask & ~i_bit_en) | (i_wdata & i_bit_en);
         end
         r_irq     <= |(r_pending & r_mask);
      end
   end

   assign o_pending   = r_pending;
   assign o_mask      = r_mask;
   assign o_interrupt = r_irq;

endmodule

// File: rtl/io_fabric.sv
// CPU bus fabric: decodes one request onto NSLAVE channels or the internal
// register block, stretching the CPU via wait_out. Option: IO_TIMEOUT_EN.
module io_fabric
   import io_fabric_pkg::*;
#(
   parameter int                   NSLAVE   = 4,
   parameter int                   AW       = 11,
   parameter int                   DW       = 32,
   parameter logic [NSLAVE*AW-1:0] BASES    = {4{11'h0}},
   parameter logic [NSLAVE*AW-1:0] MASKS    = {4{11'h7f8}},
   parameter logic [AW-1:0]        REG_BASE = 11'h7f0,
   parameter int                   TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   io_fabric_if.slave  bus
);

   localparam int            IW       = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam int            FLAG     = (DW > ERR_FLAG_BIT) ? ERR_FLAG_BIT : DW - 1;
   localparam logic [AW-1:0] REG_MASK = {{(AW-4){1'b1}}, 4'h0};

   if (NSLAVE > DW || NSLAVE < 1 || NSLAVE > 16) begin : g_bad_nslave
      $error("io_fabric: NSLAVE must be 1..16 and not exceed DW");
   end
   if (TIMEOUT < 1 || TIMEOUT > (1 << TCNT_W)) begin : g_bad_timeout
      $error("io_fabric: TIMEOUT must fit the 8-bit access counter");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_wdata;
   logic [DW/8-1:0]     r_be;
   logic                r_op_rd;
   logic                r_op_wr;
   logic                r_int;
   logic [IW-1:0]       r_idx;
   logic [NSLAVE-1:0]   r_sel;
   logic [DW-1:0]       r_dout;
   logic                r_bus_err;
   logic [DW-1:0]       r_err_addr;

   logic                w_req;
   logic                w_int_hit;
   logic                w_ch_hit;
   logic [IW-1:0]       w_idx;
   logic [NSLAVE-1:0]   w_onehot;
   logic                w_ack;
   logic                w_tmo;
   logic [NSLAVE-1:0]   w_sel;
   logic                w_rd_stb;
   logic                w_wr_stb;
   logic                w_int_rd;
   logic                w_int_wr;
   logic [DW-1:0]       w_int_rdata;
   logic [DW-1:0]       w_slv_rdata;
   logic [NSLAVE-1:0]   w_be_bits;
   logic [NSLAVE-1:0]   w_pending;
   logic [NSLAVE-1:0]   w_mask;
   logic                w_irq;
   logic                w_ofs_pend;
   logic                w_ofs_mask;
   logic                w_ofs_err;

   assign w_req = bus.read | bus.write;

   // walk from the top index down so the lowest matching channel is kept
   always_comb begin
      w_int_hit = ((bus.address & REG_MASK) == REG_BASE);
      w_ch_hit  = 1'b0;
      w_idx     = '0;
      w_onehot  = '0;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((bus.address & MASKS[i*AW +: AW]) == BASES[i*AW +: AW]) begin
            w_ch_hit    = 1'b1;
            w_idx       = IW'(i);
            w_onehot    = '0;
            w_onehot[i] = 1'b1;
         end
      end
      if (w_int_hit) begin
         w_ch_hit = 1'b0;
         w_onehot = '0;
      end
   end

   assign w_ack       = r_int | (|(bus.slv_ack & r_sel));
   assign w_slv_rdata = bus.slv_rdata[r_idx*DW +: DW];

`ifdef IO_TIMEOUT_EN
   logic [TCNT_W-1:0] r_tcnt;

   always_ff @(posedge clk) begin
      if (rst || r_state != ACCESS) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign w_tmo = (r_state == ACCESS) && !w_ack && (r_tcnt == TCNT_W'(TIMEOUT - 1));
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req) w_state_nxt = (w_int_hit || w_ch_hit) ? ACCESS : DONE;
         ACCESS:  if (w_ack || w_tmo) w_state_nxt = DONE;
         DONE:    if (!w_req) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // internal-block accesses never strobe the peripheral channels
   always_comb begin
      w_sel    = '0;
      w_rd_stb = 1'b0;
      w_wr_stb = 1'b0;
      w_int_rd = 1'b0;
      w_int_wr = 1'b0;
      if (r_state == ACCESS) begin
         if (r_int) begin
            w_int_rd = r_op_rd;
            w_int_wr = r_op_wr;
         end else begin
            w_sel    = r_sel;
            w_rd_stb = r_op_rd;
            w_wr_stb = r_op_wr;
         end
      end
   end

   assign w_ofs_pend = (r_addr[3:2] == OFS_PENDING[3:2]);
   assign w_ofs_mask = (r_addr[3:2] == OFS_MASK[3:2]);
   assign w_ofs_err  = (r_addr[3:2] == OFS_ERR_ADDR[3:2]);

   always_comb begin
      w_int_rdata = '0;
      if (w_ofs_pend) begin
         w_int_rdata[NSLAVE-1:0] = w_pending;
      end else if (w_ofs_mask) begin
         w_int_rdata[NSLAVE-1:0] = w_mask;
      end else if (w_ofs_err) begin
         w_int_rdata = r_err_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_op_rd    <= 1'b0;
         r_op_wr    <= 1'b0;
         r_int      <= 1'b0;
         r_idx      <= '0;
         r_sel      <= '0;
         r_dout     <= '0;
         r_bus_err  <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr  <= bus.address;
                  r_wdata <= bus.data_in;
                  r_be    <= bus.be;
                  r_op_wr <= bus.write;
                  r_op_rd <= bus.read & ~bus.write;
                  r_int   <= w_int_hit;
                  r_idx   <= w_idx;
                  r_sel   <= w_onehot;
                  if (!(w_int_hit || w_ch_hit)) begin
                     r_dout     <= '0;
                     r_bus_err  <= 1'b1;
                     r_err_addr <= DW'(bus.address) | (DW'(1) << FLAG);
                  end
               end
            end
            ACCESS: begin
               if (w_ack) begin
                  if (r_op_rd) begin
                     r_dout <= r_int ? w_int_rdata : w_slv_rdata;
                  end
                  if (w_int_rd && w_ofs_err) begin
                     r_err_addr[FLAG] <= 1'b0;
                  end
               end else if (w_tmo) begin
                  r_dout     <= {DW{ERR_RDATA}};
                  r_bus_err  <= 1'b1;
                  r_err_addr <= DW'(r_addr) | (DW'(1) << FLAG);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < NSLAVE; i++) begin : g_be_bits
      assign w_be_bits[i] = r_be[i/8];
   end

   io_irq_ctrl #(
      .NSLAVE (NSLAVE)
   ) u_irq (
      .clk         (clk),
      .rst         (rst),
      .i_irq       (bus.irq_in),
      .i_clr_en    (w_int_wr && w_ofs_pend),
      .i_mask_we   (w_int_wr && w_ofs_mask),
      .i_wdata     (r_wdata[NSLAVE-1:0]),
      .i_bit_en    (w_be_bits),
      .o_pending   (w_pending),
      .o_mask      (w_mask),
      .o_interrupt (w_irq)
   );

   assign bus.wait_out  = w_req && (r_state != DONE);
   assign bus.data_out  = r_dout;
   assign bus.bus_err   = r_bus_err;
   assign bus.slv_sel   = w_sel;
   assign bus.slv_read  = w_rd_stb;
   assign bus.slv_write = w_wr_stb;
   assign bus.slv_addr  = r_addr;
   assign bus.slv_wdata = r_wdata;
   assign bus.slv_be    = r_be;
   assign bus.interrupt = w_irq;

endmodule

// File: tb/tb_io_fabric.sv
// Directed bench for io_fabric: decode, wait stretching, bus errors, IRQ
// capture and reset abandonment, with hand-computed expectations.
module tb_io_fabric;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   io_fabric_if #(.NSLAVE(4), .AW(11), .DW(32)) bus ();

   // ch2 and ch3 overlap other windows: ch2 covers 0x000-0x01f, ch3 the upper half
   io_fabric #(
      .NSLAVE   (4),
      .AW       (11),
      .DW       (32),
      .BASES    ({11'h400, 11'h000, 11'h008, 11'h000}),
      .MASKS    ({11'h400, 11'h7e0, 11'h7f8, 11'h7f8}),
      .REG_BASE (11'h7f0),
      .TIMEOUT  (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // peripheral model: channel i acks after ack_dly[i] stalled cycles
   int         ack_dly [4] = '{0, 0, 5, 0};
   int         acnt = 0;
   logic [3:0] w_ack;

   always @(posedge clk) acnt <= (|bus.slv_sel) ? acnt + 1 : 0;

   always_comb begin
      w_ack = '0;
      for (int i = 0; i < 4; i++) w_ack[i] = bus.slv_sel[i] && (acnt >= ack_dly[i]);
   end

   assign bus.slv_ack   = w_ack;
   assign bus.slv_rdata = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

   int          rd_cyc = 0, wr_cyc = 0, starts = 0, err_cyc = 0, sel1_cyc = 0;
   logic        prev_stb = 1'b0;
   logic [3:0]  last_sel = '0;
   logic [31:0] last_wdata = '0;
   logic [10:0] last_waddr = '0;

   always @(negedge clk) begin
      rd_cyc   <= rd_cyc + int'(bus.slv_read);
      wr_cyc   <= wr_cyc + int'(bus.slv_write);
      err_cyc  <= err_cyc + int'(bus.bus_err);
      sel1_cyc <= sel1_cyc + int'(bus.slv_sel == 4'b0010);
      if ((bus.slv_read || bus.slv_write) && !prev_stb) starts <= starts + 1;
      prev_stb <= bus.slv_read || bus.slv_write;
      if (|bus.slv_sel) last_sel <= bus.slv_sel;
      if (bus.slv_write) begin
         last_wdata <= bus.slv_wdata;
         last_waddr <= bus.slv_addr;
      end
   end

   // one CPU transfer; wcyc counts sampled cycles with wait_out high
   task automatic cpu_xfer(input logic rd, input logic wr, input logic [10:0] addr,
                           input logic [31:0] wd, input logic [3:0] bev, input int hold,
                           input logic [3:0] irq_set,
                           output logic [31:0] rdat, output int wcyc, output logic err);
      @(negedge clk);
      bus.read    = rd;
      bus.write   = wr;
      bus.address = addr;
      bus.data_in = wd;
      bus.be      = bev;
      bus.irq_in  = bus.irq_in | irq_set;
      wcyc = 0;
      #1;
      while (bus.wait_out) begin
         wcyc++;
         if (wcyc > 200) begin
            check_val("wait_bound", 32'(bus.wait_out), 32'd0);
            break;
         end
         @(negedge clk);
         #1;
      end
      rdat = bus.data_out;
      err  = bus.bus_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         check_val("hold_wait", 32'(bus.wait_out), 32'd0);
      end
      bus.read  = 1'b0;
      bus.write = 1'b0;
   endtask

   logic [31:0] rd;
   int          wc;
   logic        er;
   int          s_rd, s_wr, s_st, s_err, s_sel1;

   task automatic snap();
      s_rd = rd_cyc; s_wr = wr_cyc; s_st = starts; s_err = err_cyc; s_sel1 = sel1_cyc;
   endtask

   initial begin
      bus.read = 0; bus.write = 0; bus.address = '0; bus.data_in = '0; bus.be = '0;
      bus.irq_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_data_out", bus.data_out, 32'h0);
      check_val("rst_wait", 32'(bus.wait_out), 32'd0);
      check_val("rst_bus_err", 32'(bus.bus_err), 32'd0);
      check_val("rst_strobes", {27'd0, bus.slv_read, bus.slv_write, bus.slv_sel}, 32'd0);
      check_val("rst_irq", 32'(bus.interrupt), 32'd0);

      // read ch1: minimum latency
      snap();
      cpu_xfer(1, 0, 11'h00C, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("ch1_wait", wc, 2);
      check_val("ch1_data", rd, 32'hC0DE_0001);
      check_val("ch1_sel_cyc", sel1_cyc - s_sel1, 1);
      check_val("ch1_rd_cyc", rd_cyc - s_rd, 1);

      // write ch0, latched write data/address
      cpu_xfer(0, 1, 11'h004, 32'hA5A5_1234, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("ch0_wr_sel", 32'(last_sel), 32'h1);
      check_val("ch0_wdata", last_wdata, 32'hA5A5_1234);
      check_val("ch0_waddr", 32'(last_waddr), 32'h004);

      // decode priority: 0x008 matches ch1 and ch2 -> ch1; 0x010 only ch2
      cpu_xfer(1, 0, 11'h008, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("prio_low_sel", 32'(last_sel), 32'h2);
      cpu_xfer(1, 0, 11'h500, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("ch3_data", rd, 32'hC0DE_0003);

      // unmapped write
      snap();
      cpu_xfer(0, 1, 11'h300, 32'h1, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("unmap_wait", wc, 1);
      check_val("unmap_bus_err", 32'(er), 32'd1);
      check_val("unmap_no_stb", (rd_cyc - s_rd) + (wr_cyc - s_wr), 0);
      check_val("unmap_err_cyc", err_cyc - s_err, 1);

      // ERR_ADDR sits inside ch3 window; the internal block must win
      snap();
      cpu_xfer(1, 0, 11'h7F8, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("err_addr", rd, 32'h8000_0300);
      check_val("int_wait", wc, 2);
      check_val("int_no_stb", rd_cyc - s_rd, 0);
      cpu_xfer(1, 0, 11'h7F8, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("err_flag_clr", rd, 32'h0000_0300);
      cpu_xfer(1, 0, 11'h7FC, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("unused_reg", rd, 32'h0);

      // ch2 slow ack, request held past DONE
      snap();
      cpu_xfer(1, 0, 11'h010, 32'h0, 4'hF, 4, 4'h0, rd, wc, er);
      check_val("ch2_wait", wc, 7);
      check_val("ch2_data", rd, 32'hC0DE_0002);
      check_val("ch2_stb_cyc", rd_cyc - s_rd, 6);
      check_val("ch2_one_access", starts - s_st, 1);

      // read and write together -> write
      snap();
      cpu_xfer(1, 1, 11'h00C, 32'h0BAD_F00D, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("rw_write_cyc", wr_cyc - s_wr, 1);
      check_val("rw_read_cyc", rd_cyc - s_rd, 0);

      // IRQ path
      cpu_xfer(0, 1, 11'h7F4, 32'h8, 4'hF, 0, 4'h0, rd, wc, er);
      @(negedge clk);
      bus.irq_in[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("irq_lag", 32'(bus.interrupt), 32'd0);
      @(negedge clk);
      check_val("irq_set", 32'(bus.interrupt), 32'd1);
      cpu_xfer(1, 0, 11'h7F0, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("pending_rd", rd, 32'h8);
      cpu_xfer(0, 1, 11'h7F0, 32'h8, 4'hF, 0, 4'h0, rd, wc, er);
      @(negedge clk);
      check_val("irq_w1c", 32'(bus.interrupt), 32'd0);
      cpu_xfer(1, 0, 11'h7F0, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("pending_clr", rd, 32'h0);

      bus.irq_in[3] = 1'b0;
      repeat (3) @(negedge clk);
      cpu_xfer(0, 1, 11'h7F0, 32'h8, 4'hF, 0, 4'h8, rd, wc, er);
      cpu_xfer(1, 0, 11'h7F0, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("set_beats_w1c", rd, 32'h8);

      cpu_xfer(0, 1, 11'h7F4, 32'h0, 4'h0, 0, 4'h0, rd, wc, er);
      cpu_xfer(1, 0, 11'h7F4, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("mask_be_off", rd, 32'h8);
      cpu_xfer(0, 1, 11'h7F4, 32'hFFFF_FFFF, 4'hF, 0, 4'h0, rd, wc, er);
      cpu_xfer(1, 0, 11'h7F4, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("mask_width", rd, 32'hF);

`ifdef IO_TIMEOUT_EN
      ack_dly[0] = 1000;
      cpu_xfer(1, 0, 11'h000, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("tmo_wait", wc, 17);
      check_val("tmo_data", rd, 32'hFFFF_FFFF);
      check_val("tmo_bus_err", 32'(er), 32'd1);
      cpu_xfer(1, 0, 11'h7F8, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("tmo_err_addr", rd, 32'h8000_0000);
      ack_dly[0] = 0;
`endif

      // reset in the middle of a stalled ch2 access; pending bit 3 is still set
      bus.irq_in = '0;
      repeat (3) @(negedge clk);
      bus.read    = 1'b1;
      bus.address = 11'h010;
      @(negedge clk);
      check_val("pre_rst_stb", 32'(bus.slv_read), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_stb", 32'(bus.slv_read), 32'd0);
      check_val("rst_mid_sel", 32'(bus.slv_sel), 32'd0);
      check_val("rst_mid_irq", 32'(bus.interrupt), 32'd0);
      bus.read = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      cpu_xfer(1, 0, 11'h7F0, 32'h0, 4'hF, 0, 4'h0, rd, wc, er);
      check_val("rst_pending", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
